// File: rtl/tlc_pkg.sv
// Shared types, lamp encodings and sizing helper for the traffic-light controller.
// The optional night-flash feature is compiled in with TLC_NIGHT_FLASH_EN.
package tlc_pkg;

  // Phase encoding; also driven out on the debug phase port.
  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FLASH  = 2'd3
  } phase_e;

  // Lamp vector order is {red, yellow, green}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YLW = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Phase counter width: enough bits to hold the largest (time - 1), never below 1.
  function automatic int cnt_width(input int red_t, input int grn_t,
                                   input int ylw_t, input int ped_t);
    int m;
    m = red_t;
    if (grn_t > m) m = grn_t;
    if (ylw_t > m) m = ylw_t;
    if (ped_t > m) m = ped_t;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// Phase-tick prescaler: one-cycle tick every TICK_DIV clocks (constant 1 when TICK_DIV=1).
module tlc_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;

  // Tick on the last prescaler count, then wrap to zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
    tick  = (pre_q == LAST);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Traffic-light controller: Moore FSM (RED/GREEN/YELLOW) with phase down-counter,
// registered one-hot lamps and a synchronised, edge-detected pedestrian request.
// Define TLC_NIGHT_FLASH_EN to add the night_mode input and the blinking FLASH state.
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int TICK_DIV       = 1,
  parameter int RED_TIME       = 16,
  parameter int GREEN_TIME     = 12,
  parameter int YELLOW_TIME    = 4,
  parameter int RED_SHORT      = 4,
  parameter int PED_GREEN_TIME = 14
) (
  input  logic       clk,
  input  logic       reset,
`ifdef TLC_NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  input  logic       ped_rqst,
  output logic       red_light,
  output logic       ylw_light,
  output logic       grn_light,
  output logic       ped_wait,
  output logic [1:0] phase
);

  localparam int CW      = cnt_width(RED_TIME, GREEN_TIME, YELLOW_TIME, PED_GREEN_TIME);
  localparam int PED_GRN = (GREEN_TIME > PED_GREEN_TIME) ? GREEN_TIME : PED_GREEN_TIME;

  localparam logic [CW-1:0] LD_RED       = CW'(RED_TIME - 1);
  localparam logic [CW-1:0] LD_RED_SHORT = CW'(RED_SHORT - 1);
  localparam logic [CW-1:0] LD_GREEN     = CW'(GREEN_TIME - 1);
  localparam logic [CW-1:0] LD_PED_GREEN = CW'(PED_GRN - 1);
  localparam logic [CW-1:0] LD_YELLOW    = CW'(YELLOW_TIME - 1);

  phase_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    lamps_q, lamps_d;
  logic          ped_wait_q, ped_wait_d;
  logic          sync1_q, sync2_q, sync3_q;
  logic          tick;
  logic          ped_edge;
  logic          pend_eff;

  tlc_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // A request counts once per rising edge of the synchronised level.
  assign ped_edge = sync2_q & ~sync3_q;
  assign pend_eff = ped_wait_q | ped_edge;

  // Next state, phase counter, request latch and lamp decode of the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ped_wait_d = ped_wait_q | ped_edge;
    lamps_d    = lamps_q;

    case (state_q)
      RED: begin
        if (tick && cnt_q == '0) begin
          state_d    = GREEN;
          cnt_d      = pend_eff ? LD_PED_GREEN : LD_GREEN;
          ped_wait_d = 1'b0;
        end else if (pend_eff && cnt_q > LD_RED_SHORT) begin
          // Cut red short, but never lengthen it.
          cnt_d = LD_RED_SHORT;
        end else if (tick) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GREEN: begin
        if (tick && cnt_q == '0) begin
          state_d = YELLOW;
          cnt_d   = LD_YELLOW;
        end else if (tick) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      YELLOW: begin
        if (tick && cnt_q == '0) begin
          state_d = RED;
          cnt_d   = pend_eff ? LD_RED_SHORT : LD_RED;
        end else if (tick) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef TLC_NIGHT_FLASH_EN
      FLASH: begin
        if (!night_mode) begin
          state_d = RED;
          cnt_d   = LD_RED;
        end
      end
`endif
      default: begin
        state_d = RED;
        cnt_d   = LD_RED;
      end
    endcase

`ifdef TLC_NIGHT_FLASH_EN
    // Night mode takes over at the end of whatever phase is running.
    if (night_mode && state_q != FLASH && tick && cnt_q == '0) begin
      state_d = FLASH;
      cnt_d   = '0;
    end
    if (state_d == FLASH) ped_wait_d = 1'b0;
`endif

    case (state_d)
      GREEN:  lamps_d = LAMP_GRN;
      YELLOW: lamps_d = LAMP_YLW;
`ifdef TLC_NIGHT_FLASH_EN
      FLASH: begin
        if (state_q != FLASH) lamps_d = LAMP_YLW;
        else if (tick)        lamps_d = lamps_q ^ LAMP_YLW;
      end
`endif
      default: lamps_d = LAMP_RED;
    endcase
  end

  // State, counter, lamp, request latch and synchroniser registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RED;
      cnt_q      <= LD_RED;
      lamps_q    <= LAMP_RED;
      ped_wait_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lamps_q    <= lamps_d;
      ped_wait_q <= ped_wait_d;
      // NOTE: sync1 may go metastable; only sync2 onward is used by logic.
      sync1_q    <= ped_rqst;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
    end
  end

  assign {red_light, ylw_light, grn_light} = lamps_q;
  assign ped_wait = ped_wait_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed self-checking bench for traffic_light_ctrl
// (TICK_DIV=1, RED=8, GREEN=6, YELLOW=3, RED_SHORT=3, PED_GREEN=10).
module tb_traffic_light_ctrl;

  logic       clk;
  logic       reset;
  logic       ped_rqst;
`ifdef TLC_NIGHT_FLASH_EN
  logic       night_mode;
`endif
  logic       red_light, ylw_light, grn_light, ped_wait;
  logic [1:0] phase;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [5:0] o_vec, e_vec;
  logic [1:0] ph;
  logic       pw;

  traffic_light_ctrl #(
    .TICK_DIV       (1),
    .RED_TIME       (8),
    .GREEN_TIME     (6),
    .YELLOW_TIME    (3),
    .RED_SHORT      (3),
    .PED_GREEN_TIME (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef TLC_NIGHT_FLASH_EN
    .night_mode(night_mode),
`endif
    .ped_rqst  (ped_rqst),
    .red_light (red_light),
    .ylw_light (ylw_light),
    .grn_light (grn_light),
    .ped_wait  (ped_wait),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected phase at cycle c given alternating red/green/yellow segment lengths.
  function automatic logic [1:0] seg_phase(input int c, input int s0, input int s1,
                                           input int s2, input int s3, input int s4,
                                           input int s5);
    int b;
    b = s0;      if (c < b) return 2'd0;
    b = b + s1;  if (c < b) return 2'd1;
    b = b + s2;  if (c < b) return 2'd2;
    b = b + s3;  if (c < b) return 2'd0;
    b = b + s4;  if (c < b) return 2'd1;
    b = b + s5;  if (c < b) return 2'd2;
    return 2'd0;
  endfunction

  // Expected lamps {red, yellow, green} for a phase.
  function automatic logic [2:0] lamp_of(input logic [1:0] p);
    case (p)
      2'd0:    return 3'b100;
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Synchronous reset for two edges; leaves the DUT at red cycle 0.
  task automatic do_reset();
    reset    = 1'b1;
    ped_rqst = 1'b0;
`ifdef TLC_NIGHT_FLASH_EN
    night_mode = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ped_rqst = 1'b1;
`ifdef TLC_NIGHT_FLASH_EN
    night_mode = 1'b0;
`endif
    step();
    step();
    n_total++;
    if ({red_light, ylw_light, grn_light} !== 3'b100)
      $display("FAIL reset_lamps got %b exp 100", {red_light, ylw_light, grn_light});
    else n_pass++;
    n_total++;
    if (phase !== 2'd0) $display("FAIL reset_phase got %0d exp 0", phase);
    else n_pass++;
    n_total++;
    if (ped_wait !== 1'b0) $display("FAIL reset_ped_wait got %b exp 0", ped_wait);
    else n_pass++;
    repeat (4) step();
    n_total++;
    if ({red_light, ylw_light, grn_light, phase, ped_wait} !== 6'b100_00_0)
      $display("FAIL reset_hold got %b exp 100000",
               {red_light, ylw_light, grn_light, phase, ped_wait});
    else n_pass++;
    ped_rqst = 1'b0;
  endtask

  task automatic test_normal_cycle();
    do_reset();
    for (int c = 0; c < 36; c++) begin
      ph    = seg_phase(c, 8, 6, 3, 8, 6, 3);
      e_vec = {lamp_of(ph), ph, 1'b0};
      o_vec = {red_light, ylw_light, grn_light, phase, ped_wait};
      n_total++;
      if (o_vec !== e_vec) $display("FAIL normal c=%0d got %b exp %b", c, o_vec, e_vec);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_ped_in_red();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      ph    = seg_phase(c, 6, 10, 3, 8, 6, 3);
      pw    = (c >= 3 && c < 6);
      e_vec = {lamp_of(ph), ph, pw};
      o_vec = {red_light, ylw_light, grn_light, phase, ped_wait};
      n_total++;
      if (o_vec !== e_vec) $display("FAIL ped_red c=%0d got %b exp %b", c, o_vec, e_vec);
      else n_pass++;
      if (c == 0) ped_rqst = 1'b1;
      if (c == 1) ped_rqst = 1'b0;
      step();
    end
  endtask

  task automatic test_ped_in_green();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      ph    = seg_phase(c, 8, 6, 3, 3, 10, 3);
      pw    = (c >= 13 && c < 20);
      e_vec = {lamp_of(ph), ph, pw};
      o_vec = {red_light, ylw_light, grn_light, phase, ped_wait};
      n_total++;
      if (o_vec !== e_vec) $display("FAIL ped_green c=%0d got %b exp %b", c, o_vec, e_vec);
      else n_pass++;
      if (c == 10) ped_rqst = 1'b1;
      if (c == 11) ped_rqst = 1'b0;
      step();
    end
  endtask

  task automatic test_held_request();
    do_reset();
    for (int c = 0; c < 44; c++) begin
      ph    = seg_phase(c, 6, 10, 3, 8, 6, 3);
      pw    = (c >= 3 && c < 6);
      e_vec = {lamp_of(ph), ph, pw};
      o_vec = {red_light, ylw_light, grn_light, phase, ped_wait};
      n_total++;
      if (o_vec !== e_vec) $display("FAIL held c=%0d got %b exp %b", c, o_vec, e_vec);
      else n_pass++;
      if (c == 0)  ped_rqst = 1'b1;
      if (c == 40) ped_rqst = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid_green();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      ph    = seg_phase(c, 8, 6, 3, 8, 6, 3);
      pw    = (c == 11);
      e_vec = {lamp_of(ph), ph, pw};
      o_vec = {red_light, ylw_light, grn_light, phase, ped_wait};
      n_total++;
      if (o_vec !== e_vec) $display("FAIL mid_pre c=%0d got %b exp %b", c, o_vec, e_vec);
      else n_pass++;
      if (c == 8)  ped_rqst = 1'b1;
      if (c == 9)  ped_rqst = 1'b0;
      if (c == 11) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ph    = (k < 8) ? 2'd0 : 2'd1;
      e_vec = {lamp_of(ph), ph, 1'b0};
      o_vec = {red_light, ylw_light, grn_light, phase, ped_wait};
      n_total++;
      if (o_vec !== e_vec) $display("FAIL mid_post k=%0d got %b exp %b", k, o_vec, e_vec);
      else n_pass++;
      step();
    end
  endtask

`ifdef TLC_NIGHT_FLASH_EN
  task automatic test_night_flash();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      ph    = seg_phase(c, 8, 6, 3, 8, 6, 3);
      e_vec = {lamp_of(ph), ph, 1'b0};
      o_vec = {red_light, ylw_light, grn_light, phase, ped_wait};
      n_total++;
      if (o_vec !== e_vec) $display("FAIL night_pre c=%0d got %b exp %b", c, o_vec, e_vec);
      else n_pass++;
      if (c == 9) night_mode = 1'b1;
      step();
    end
    for (int f = 0; f < 10; f++) begin
      e_vec = {1'b0, (f % 2 == 0), 1'b0, 2'd3, 1'b0};
      o_vec = {red_light, ylw_light, grn_light, phase, ped_wait};
      n_total++;
      if (o_vec !== e_vec) $display("FAIL flash f=%0d got %b exp %b", f, o_vec, e_vec);
      else n_pass++;
      if (f == 1) ped_rqst = 1'b1;
      if (f == 2) ped_rqst = 1'b0;
      if (f == 9) night_mode = 1'b0;
      step();
    end
    for (int k = 0; k < 10; k++) begin
      ph    = (k < 8) ? 2'd0 : 2'd1;
      e_vec = {lamp_of(ph), ph, 1'b0};
      o_vec = {red_light, ylw_light, grn_light, phase, ped_wait};
      n_total++;
      if (o_vec !== e_vec) $display("FAIL night_exit k=%0d got %b exp %b", k, o_vec, e_vec);
      else n_pass++;
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal_cycle();
    test_ped_in_red();
    test_ped_in_green();
    test_held_request();
    test_reset_mid_green();
`ifdef TLC_NIGHT_FLASH_EN
    test_night_flash();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
